stm_spi_slave: RTL and testbench

//  SPI mode-0 responder (CPOL=0, CPHA=0, MSB first) on the FPGA side of the STM32 link (stm_sck/stm_ss/stm_mosi in, stm_miso out).
//  The STM32 is the initiator. This block oversamples its pins in the clk domain and delivers received bytes as single-cycle strobes.
//  It returns bytes from a one-deep tx holding register that the command/status logic fills through a valid/ready handshake.

---
 rtl/stm_spi_slave.sv | 220 ++++++++++++++++++++++
 tb/tb_stm_spi_slave.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/stm_spi_slave.sv
// SPI mode-0 responder for the STM32 link. The pins are oversampled in the clk
// domain, received bytes come out as single-cycle strobes, and transmit bytes
// come from a one-deep holding register filled through a valid/ready handshake.
//
//  state      | meaning
//  -----------+-------------------------------------------------------------
//  ST_IDLE    | no frame; waiting for synchronized ss to fall
//  ST_ACTIVE  | frame in progress; sck edges shift data in and out
//  ST_ARMWAIT | reset arrived mid-frame; ignore sck until ss is seen high
module stm_spi_slave #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] TX_IDLE     = 8'hFF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sck,
    input  logic       ss,
    input  logic       mosi,
    output logic       miso,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_underrun,
    output logic       frame_start,
    output logic       frame_end,
    output logic       busy,
    output logic [7:0] frame_bytes
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACTIVE  = 2'd1,
        ST_ARMWAIT = 2'd2
    } state_t;

    // The arm counter covers the synchronizer flush after reset, so a stale
    // reset-value "ss high" is never mistaken for the master releasing ss.
    localparam int ARM_W = $clog2(SYNC_STAGES + 2);
    localparam logic [ARM_W-1:0] ARM_LOAD = ARM_W'(SYNC_STAGES + 1);

    logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
    logic [SYNC_STAGES-1:0] ss_sync_q, ss_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic                   sck_prev_q, sck_prev_d;
    logic                   ss_prev_q, ss_prev_d;

    state_t     state_q, state_d;
    logic [ARM_W-1:0] arm_cnt_q, arm_cnt_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [6:0] rx_sr_q, rx_sr_d;
    logic [7:0] tx_sr_q, tx_sr_d;
    logic [7:0] hold_q, hold_d;
    logic       hold_full_q, hold_full_d;
    logic       miso_q, miso_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       tx_underrun_q, tx_underrun_d;
    logic       frame_start_q, frame_start_d;
    logic       frame_end_q, frame_end_d;
    logic [7:0] frame_bytes_q, frame_bytes_d;

    logic sck_s, ss_s, mosi_s;
    logic sck_rise, sck_fall, ss_rise, ss_fall;
    logic load;

    assign sck_s    = sck_sync_q[SYNC_STAGES-1];
    assign ss_s     = ss_sync_q[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
    assign sck_rise =  sck_s & ~sck_prev_q;
    assign sck_fall = ~sck_s &  sck_prev_q;
    assign ss_rise  =  ss_s  & ~ss_prev_q;
    assign ss_fall  = ~ss_s  &  ss_prev_q;

    // Synchronizers, frame FSM, shift registers and holding-register handshake.
    always_comb begin
        sck_sync_d    = {sck_sync_q[SYNC_STAGES-2:0], sck};
        ss_sync_d     = {ss_sync_q[SYNC_STAGES-2:0], ss};
        mosi_sync_d   = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
        sck_prev_d    = sck_s;
        ss_prev_d     = ss_s;
        state_d       = state_q;
        arm_cnt_d     = arm_cnt_q;
        bit_cnt_d     = bit_cnt_q;
        rx_sr_d       = rx_sr_q;
        tx_sr_d       = tx_sr_q;
        hold_d        = hold_q;
        hold_full_d   = hold_full_q;
        miso_d        = miso_q;
        rx_data_d     = rx_data_q;
        rx_valid_d    = 1'b0;
        tx_underrun_d = 1'b0;
        frame_start_d = 1'b0;
        frame_end_d   = 1'b0;
        frame_bytes_d = frame_bytes_q;
        load          = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (ss_fall) begin
                    state_d       = ST_ACTIVE;
                    frame_start_d = 1'b1;
                    frame_bytes_d = 8'd0;
                    bit_cnt_d     = 3'd0;
                    load          = 1'b1;
                end
            end
            ST_ACTIVE: begin
                // ss rise has priority over any sck edge seen on the same cycle
                if (ss_rise) begin
                    state_d     = ST_IDLE;
                    frame_end_d = 1'b1;
                    bit_cnt_d   = 3'd0;
                    miso_d      = 1'b0;
                end else if (sck_rise) begin
                    rx_sr_d   = {rx_sr_q[5:0], mosi_s};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        rx_data_d     = {rx_sr_q, mosi_s};
                        rx_valid_d    = 1'b1;
                        frame_bytes_d = frame_bytes_q + 8'd1;
                    end
                end else if (sck_fall) begin
                    if (bit_cnt_q == 3'd0) begin
                        load = 1'b1;
                    end else begin
                        miso_d  = tx_sr_q[7];
                        tx_sr_d = {tx_sr_q[6:0], 1'b0};
                    end
                end
            end
            ST_ARMWAIT: begin
                if (arm_cnt_q != '0) begin
                    arm_cnt_d = arm_cnt_q - ARM_W'(1);
                end else if (ss_s) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Byte boundary: take the held byte, or send the idle pattern.
        if (load) begin
            if (hold_full_q) begin
                miso_d      = hold_q[7];
                tx_sr_d     = {hold_q[6:0], 1'b0};
                hold_full_d = 1'b0;
            end else begin
                miso_d        = TX_IDLE[7];
                tx_sr_d       = {TX_IDLE[6:0], 1'b0};
                tx_underrun_d = 1'b1;
            end
        end

        // Acceptance uses the registered ready, so a byte offered on a load
        // cycle waits for the next boundary rather than bypassing the holder.
        if (tx_valid && !hold_full_q) begin
            hold_d      = tx_data;
            hold_full_d = 1'b1;
        end
    end

    // State registers with synchronous reset; a reset during a frame arms a
    // wait so the interrupted frame is discarded.
    always_ff @(posedge clk) begin
        if (rst) begin
            sck_sync_q    <= '0;
            ss_sync_q     <= '1;
            mosi_sync_q   <= '0;
            sck_prev_q    <= 1'b0;
            ss_prev_q     <= 1'b1;
            state_q       <= ss ? ST_IDLE : ST_ARMWAIT;
            arm_cnt_q     <= ARM_LOAD;
            bit_cnt_q     <= 3'd0;
            rx_sr_q       <= 7'd0;
            tx_sr_q       <= 8'd0;
            hold_q        <= 8'd0;
            hold_full_q   <= 1'b0;
            miso_q        <= 1'b0;
            rx_data_q     <= 8'd0;
            rx_valid_q    <= 1'b0;
            tx_underrun_q <= 1'b0;
            frame_start_q <= 1'b0;
            frame_end_q   <= 1'b0;
            frame_bytes_q <= 8'd0;
        end else begin
            sck_sync_q    <= sck_sync_d;
            ss_sync_q     <= ss_sync_d;
            mosi_sync_q   <= mosi_sync_d;
            sck_prev_q    <= sck_prev_d;
            ss_prev_q     <= ss_prev_d;
            state_q       <= state_d;
            arm_cnt_q     <= arm_cnt_d;
            bit_cnt_q     <= bit_cnt_d;
            rx_sr_q       <= rx_sr_d;
            tx_sr_q       <= tx_sr_d;
            hold_q        <= hold_d;
            hold_full_q   <= hold_full_d;
            miso_q        <= miso_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            tx_underrun_q <= tx_underrun_d;
            frame_start_q <= frame_start_d;
            frame_end_q   <= frame_end_d;
            frame_bytes_q <= frame_bytes_d;
        end
    end

    assign miso        = miso_q;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign tx_ready    = ~hold_full_q;
    assign tx_underrun = tx_underrun_q;
    assign frame_start = frame_start_q;
    assign frame_end   = frame_end_q;
    assign busy        = (state_q == ST_ACTIVE);
    assign frame_bytes = frame_bytes_q;

endmodule

// File: tb/tb_stm_spi_slave.sv
// Testbench for stm_spi_slave: an STM32-style SPI master drives frames, a
// byte-level reference model predicts miso bytes and strobe counts, and a
// monitor pops expected received bytes whenever rx_valid fires.
module tb_stm_spi_slave;

    localparam int SYNC = 2;
    localparam int HALF = 5;   // sck half period in clk cycles (clk/10)

    logic       clk = 1'b0;
    logic       rst;
    logic       sck;
    logic       ss;
    logic       mosi;
    logic       miso;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_underrun;
    logic       frame_start;
    logic       frame_end;
    logic       busy;
    logic [7:0] frame_bytes;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int last_rise_cyc = 0;
    int n_fs = 0, n_fe = 0, n_ur = 0;
    int e_fs = 0, e_fe = 0, e_ur = 0;

    logic [7:0] exp_rx[$];
    logic [7:0] exp_tx[$];
    logic       m_full = 1'b0;
    logic [7:0] m_hold = 8'h00;

    stm_spi_slave #(.SYNC_STAGES(SYNC), .TX_IDLE(8'hFF)) dut (
        .clk         (clk),
        .rst         (rst),
        .sck         (sck),
        .ss          (ss),
        .mosi        (mosi),
        .miso        (miso),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .tx_underrun (tx_underrun),
        .frame_start (frame_start),
        .frame_end   (frame_end),
        .busy        (busy),
        .frame_bytes (frame_bytes)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops the expected received byte on every rx_valid and counts strobes.
    always @(negedge clk) begin
        logic [7:0] e;
        if (!rst) begin
            if (rx_valid) begin
                if (exp_rx.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rx_unexpected: got %02h expected no byte", rx_data);
                end else begin
                    e = exp_rx.pop_front();
                    chk("rx_data", rx_data, e);
                    chk("rx_latency", ((cyc - last_rise_cyc) <= 4), 1);
                end
            end
            if (tx_underrun) n_ur++;
            if (frame_start) n_fs++;
            if (frame_end)   n_fe++;
        end
    end

    // Reference model of one byte boundary.
    function automatic void model_load();
        if (m_full) begin
            exp_tx.push_back(m_hold);
            m_full = 1'b0;
        end else begin
            exp_tx.push_back(8'hFF);
            e_ur++;
        end
    endfunction

    task automatic offer(input logic [7:0] b);
        int n = 0;
        while (!tx_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("tx_ready_wait", tx_ready, 1);
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        m_hold = b;
        m_full = 1'b1;
    endtask

    task automatic spi_bit(input logic bv, output logic mv);
        mosi = bv;
        repeat (HALF) @(negedge clk);
        mv = miso;
        sck = 1'b1;
        last_rise_cyc = cyc;
        repeat (HALF) @(negedge clk);
        sck = 1'b0;
    endtask

    task automatic spi_byte(input logic [7:0] b, input bit offer_mid, input logic [7:0] ob);
        logic [7:0] got;
        logic mv;
        logic [7:0] e;
        exp_rx.push_back(b);
        for (int i = 7; i >= 0; i--) begin
            spi_bit(b[i], mv);
            got[i] = mv;
            if (i == 4 && offer_mid && !m_full) offer(ob);
        end
        e = exp_tx.pop_front();
        chk("miso_byte", got, e);
        model_load();   // trailing sck fall is a byte boundary
    endtask

    task automatic frame_begin();
        ss = 1'b0;
        e_fs++;
        model_load();
        repeat (HALF + 1) @(negedge clk);
        chk("busy_in_frame", busy, 1);
    endtask

    task automatic frame_close(input int nb);
        repeat (HALF) @(negedge clk);
        chk("frame_bytes", frame_bytes, nb);
        ss = 1'b1;
        e_fe++;
        repeat (HALF + 1) @(negedge clk);
        chk("busy_idle", busy, 0);
        chk("miso_idle", miso, 0);
        chk("frame_start_cnt", n_fs, e_fs);
        chk("frame_end_cnt", n_fe, e_fe);
        chk("underrun_cnt", n_ur, e_ur);
        chk("rx_pending", exp_rx.size(), 0);
        exp_tx.delete();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic mv;
        int nb;
        rst = 1'b1; ss = 1'b1; sck = 1'b0; mosi = 1'b0;
        tx_data = 8'h00; tx_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_miso", miso, 0);
        chk("rst_tx_ready", tx_ready, 1);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_bytes", frame_bytes, 0);
        chk("rst_rx_data", rx_data, 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Single byte: A5 out, 3C in.
        offer(8'hA5);
        frame_begin();
        spi_byte(8'h3C, 1'b0, 8'h00);
        frame_close(1);

        // Three bytes with only one byte loaded.
        offer(8'h12);
        frame_begin();
        spi_byte(8'h9A, 1'b0, 8'h00);
        spi_byte(8'h0F, 1'b0, 8'h00);
        spi_byte(8'hE1, 1'b0, 8'h00);
        frame_close(3);

        // Partial byte discarded, then a clean frame.
        frame_begin();
        for (int i = 0; i < 5; i++) spi_bit(1'b1, mv);
        frame_close(0);
        frame_begin();
        spi_byte(8'h81, 1'b0, 8'h00);
        frame_close(1);

        // Reset in the middle of a frame.
        frame_begin();
        for (int i = 0; i < 4; i++) spi_bit(1'b0, mv);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_miso", miso, 0);
        chk("mid_rst_rx_valid", rx_valid, 0);
        chk("mid_rst_tx_ready", tx_ready, 1);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_frame_bytes", frame_bytes, 0);
        chk("mid_rst_rx_data", rx_data, 0);
        chk("mid_rst_strobes", {tx_underrun, frame_start, frame_end}, 0);
        @(negedge clk);
        rst = 1'b0;
        m_full = 1'b0;
        exp_tx.delete();
        for (int i = 0; i < 4; i++) spi_bit(1'b1, mv);
        repeat (HALF) @(negedge clk);
        chk("armwait_busy", busy, 0);
        chk("armwait_miso", miso, 0);
        ss = 1'b1;
        repeat (10) @(negedge clk);
        chk("armwait_frame_end_cnt", n_fe, e_fe);
        chk("armwait_rx_pending", exp_rx.size(), 0);
        frame_begin();
        spi_byte(8'h55, 1'b0, 8'h00);
        frame_close(1);

        // tx_valid on the exact load cycle with the holder empty.
        ss = 1'b0;
        e_fs++;
        repeat (SYNC) @(negedge clk);
        tx_data  = 8'h77;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        model_load();
        m_hold = 8'h77;
        m_full = 1'b1;
        repeat (HALF) @(negedge clk);
        spi_byte(8'hC3, 1'b0, 8'h00);
        spi_byte(8'h5A, 1'b0, 8'h00);
        frame_close(2);

        // Randomized frames.
        for (int f = 0; f < 20; f++) begin
            if (!m_full && $urandom_range(0, 1) == 1) offer(8'($urandom));
            frame_begin();
            if ($urandom_range(0, 5) == 0) begin
                nb = $urandom_range(1, 7);
                for (int i = 0; i < nb; i++) spi_bit(1'($urandom), mv);
                frame_close(0);
            end else begin
                nb = $urandom_range(1, 4);
                for (int i = 0; i < nb; i++)
                    spi_byte(8'($urandom), 1'($urandom), 8'($urandom));
                frame_close(nb);
            end
            repeat ($urandom_range(2, 8)) @(negedge clk);
        end

        chk("final_rx_pending", exp_rx.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
